spi_flash_read_arb: RTL and testbench

Shared SPI flash read controller that sits between two read requesters (port 0: instruction fetch, port 1: data/debug load) and the board SPI flash (`spi_cs_n`/`spi_sck`/`spi_mosi`/`spi_miso`).
- Arbitrates round-robin between the two ports.
- Issues one standard READ (0x03) transaction per grant and returns one 32-bit little-endian word.
- Keeps chip-select high for a programmable gap between transactions.

---
 rtl/spi_flash_read_arb.sv | 164 ++++++++++++++++
 tb/tb_spi_flash_read_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_read_arb.sv
// Two-port round-robin SPI flash reader: one READ (0x03) per grant, returns a
// little-endian 32-bit word and keeps chip-select high for a minimum gap.
module spi_flash_read_arb #(
  parameter int SCK_DIV = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [23:0] m0_addr,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [23:0] m1_addr,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy
);
  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GAP_W = $clog2(CS_GAP + 1) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_GAP} state_t;
  state_t r_state, w_state_next;

  logic             r_cs_n, r_sck, r_mosi, r_busy, r_last_grant, r_port;
  logic             r_m0_ack, r_m1_ack;
  logic [31:0]      r_m0_rdata, r_m1_rdata;
  logic [62:0]      r_tx;  // frame bits still to go after the one on MOSI
  logic [31:0]      r_rx;
  logic [5:0]       r_bit;
  logic [DIV_W-1:0] r_div;
  logic [GAP_W-1:0] r_gap;

  logic        w_any_req, w_grant_port, w_phase_end, w_last_bit, w_gap_end, w_grant;
  logic [21:0] w_addr_hi;
  logic [31:0] w_word;
  logic        w_unused_addr_lsbs;

  assign w_any_req    = m0_req | m1_req;
  assign w_grant_port = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_addr_hi    = w_grant_port ? m1_addr[23:2] : m0_addr[23:2];
  assign w_phase_end  = (r_div == DIV_LAST);
  assign w_last_bit   = (r_bit == 6'd63);
  assign w_gap_end    = (r_gap >= GAP_LAST);
  assign w_unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // Bytes arrive first-byte-first; the first byte is the least significant.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bswap
    assign w_word[8*gi +: 8] = r_rx[8*(3-gi) +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_sck && w_phase_end && w_last_bit) w_state_next = S_DONE;
      end
      S_DONE, S_GAP: begin
        if (w_gap_end) begin
          if (w_any_req) begin
            w_grant      = 1'b1;
            w_state_next = S_SHIFT;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_state_next = S_GAP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n       <= 1'b1;
      r_sck        <= 1'b0;
      r_mosi       <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_bit        <= '0;
      r_div        <= '0;
      r_gap        <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      if (w_grant) begin
        r_cs_n       <= 1'b0;
        r_sck        <= 1'b0;
        r_busy       <= 1'b1;
        r_mosi       <= CMD_READ[7];
        r_tx         <= {CMD_READ[6:0], w_addr_hi, 2'b00, 32'h0};
        r_port       <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_bit        <= '0;
        r_div        <= '0;
      end else if (r_state == S_SHIFT) begin
        r_div <= w_phase_end ? '0 : r_div + 1'b1;
        if (w_phase_end) begin
          if (!r_sck) begin
            r_sck <= 1'b1;
            r_rx  <= {r_rx[30:0], spi_miso};
          end else if (w_last_bit) begin
            r_cs_n <= 1'b1;
            r_sck  <= 1'b0;
            r_mosi <= 1'b0;
            r_gap  <= GAP_W'(1);  // the DONE cycle is the first gap cycle
            if (r_port) begin
              r_m1_ack   <= 1'b1;
              r_m1_rdata <= w_word;
            end else begin
              r_m0_ack   <= 1'b1;
              r_m0_rdata <= w_word;
            end
          end else begin
            r_sck  <= 1'b0;
            r_bit  <= r_bit + 1'b1;
            r_mosi <= r_tx[62];
            r_tx   <= {r_tx[61:0], 1'b0};
          end
        end
      end else if (r_state == S_DONE || r_state == S_GAP) begin
        if (w_gap_end) r_busy <= 1'b0;
        else           r_gap  <= r_gap + 1'b1;
      end
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;
  assign spi_cs_n = r_cs_n;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_flash_read_arb.sv
// Scoreboard bench for spi_flash_read_arb: two instances (SCK_DIV 1 and 3),
// each with a behavioural SPI flash model and an ack-driven monitor.
module tb_spi_flash_read_arb;
  typedef struct {
    int          inst;
    int          port;
    logic [31:0] rdata;
    logic [31:0] hdr;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [7:0] flash_mem [int];
  bit   chk_gap = 1'b0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (flash_mem.exists(int'(a))) return flash_mem[int'(a)];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int DIV = (gi == 0) ? 1 : 3;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [23:0] m0_addr = '0, m1_addr = '0;
    logic        m0_ack, m1_ack, cs_n, sck, mosi, busy;
    logic        miso = 1'b0;
    logic [31:0] m0_rdata, m1_rdata;

    spi_flash_read_arb #(.SCK_DIV(DIV), .CS_GAP(2)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso), .busy(busy)
    );

    // Flash model: latch cmd+addr on rising SCK, shift data out on falling SCK.
    int          nbits = 0;
    int          proto_bad = 0;
    logic [31:0] hdr = '0;
    always @(negedge cs_n) begin
      nbits = 0;
      hdr = '0;
      proto_bad = 0;
    end
    always @(posedge sck) begin
      if (cs_n === 1'b0) begin
        if (nbits < 32) hdr = {hdr[30:0], mosi};
        else if (mosi !== 1'b0) proto_bad++;
        nbits++;
      end
    end
    always @(negedge sck) begin
      logic [7:0] b;
      int k;
      if (cs_n === 1'b0 && nbits >= 32 && nbits < 64) begin
        k = nbits - 32;
        b = flash_byte(hdr[23:0] + 24'(k / 8));
        miso = b[7 - (k % 8)];
      end
    end

    // Monitor: samples on the falling clk edge, pops the scoreboard on ack.
    int          cyc = 0, grant_cyc = 0, ack_cyc = 0, gap_cnt = 0, run = 0, sck_bad = 0;
    bit          ack_valid = 1'b0, in_frame = 1'b0;
    logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;
    logic [31:0] hold0 = '0, hold1 = '0;
    exp_t        e;
    int          p;
    always @(negedge clk) begin
      cyc++;
      if (rst === 1'b1) begin
        ack_valid = 1'b0;
        in_frame  = 1'b0;
        hold0     = '0;
        hold1     = '0;
        gap_cnt   = 0;
      end else begin
        if (prev_cs === 1'b1 && cs_n === 1'b0) begin
          grant_cyc = cyc;
          in_frame  = 1'b1;
          run       = 1;
          sck_bad   = 0;
          chk($sformatf("inst%0d_busy_at_grant", gi), 32'(busy), 32'd1);
          if (chk_gap && ack_valid) chk($sformatf("inst%0d_cs_gap", gi), gap_cnt, 2);
          gap_cnt = 0;
        end else if (in_frame && cs_n === 1'b0) begin
          if (sck === prev_sck) run++;
          else begin
            if (run != DIV) sck_bad++;
            run = 1;
          end
          if (sck === 1'b1 && mosi !== prev_mosi) sck_bad++;
        end
        if (cs_n === 1'b1) gap_cnt++;

        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
          p = (m1_ack === 1'b1) ? 1 : 0;
          chk($sformatf("inst%0d_ack_onehot", gi), 32'({m0_ack, m1_ack} == 2'b11), 32'd0);
          chk($sformatf("inst%0d_ack_expected", gi), 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("inst%0d_instance", gi), gi, e.inst);
            chk($sformatf("inst%0d_port", gi), p, e.port);
            chk($sformatf("inst%0d_rdata", gi), p ? m1_rdata : m0_rdata, e.rdata);
            chk($sformatf("inst%0d_mosi_hdr", gi), hdr, e.hdr);
            chk($sformatf("inst%0d_latency", gi), cyc - grant_cyc, e.lat);
            chk($sformatf("inst%0d_other_rdata", gi), p ? m0_rdata : m1_rdata, p ? hold0 : hold1);
            chk($sformatf("inst%0d_cs_high_at_ack", gi), 32'(cs_n), 32'd1);
            chk($sformatf("inst%0d_sck_mosi_timing", gi), sck_bad + proto_bad, 0);
            $display("inst%0d port%0d ack rdata=0x%08h hdr=0x%08h lat=%0d", gi, p,
                     p ? m1_rdata : m0_rdata, hdr, cyc - grant_cyc);
          end
          hold0     = m0_rdata;
          hold1     = m1_rdata;
          ack_valid = 1'b1;
          ack_cyc   = cyc;
          in_frame  = 1'b0;
        end
        if (prev_busy === 1'b1 && busy === 1'b0 && ack_valid)
          chk($sformatf("inst%0d_busy_fall", gi), cyc - ack_cyc, 2);
      end
      prev_cs   = cs_n;
      prev_sck  = sck;
      prev_mosi = mosi;
      prev_busy = busy;
    end
  end

  task automatic set_req(input int inst, input int port, input logic v, input logic [23:0] a);
    if (inst == 0) begin
      if (port == 0) begin g_inst[0].m0_req = v; g_inst[0].m0_addr = a; end
      else begin g_inst[0].m1_req = v; g_inst[0].m1_addr = a; end
    end else begin
      if (port == 0) begin g_inst[1].m0_req = v; g_inst[1].m0_addr = a; end
      else begin g_inst[1].m1_req = v; g_inst[1].m1_addr = a; end
    end
  endtask

  function automatic logic sel_ack(input int inst, input int port);
    if (inst == 0) return (port == 0) ? g_inst[0].m0_ack : g_inst[0].m1_ack;
    return (port == 0) ? g_inst[1].m0_ack : g_inst[1].m1_ack;
  endfunction

  task automatic expect_tx(input int inst, input int port, input logic [31:0] rd,
                           input logic [31:0] hdr, input int lat);
    exp_t x;
    x.inst = inst; x.port = port; x.rdata = rd; x.hdr = hdr; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic wait_ack(input int inst, input int port, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel_ack(inst, port) !== 1'b1 && n < 1500);
    chk({name, "_ack_seen"}, 32'(sel_ack(inst, port)), 32'd1);
  endtask

  task automatic wait_grant0(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (g_inst[0].cs_n !== 1'b0 && n < 20);
    chk({name, "_grant_seen"}, 32'(g_inst[0].cs_n), 32'd0);
  endtask

  // Single read on one port: raise, hold until ack, then drop.
  task automatic read_one(input int inst, input int port, input logic [23:0] a, input string name);
    @(posedge clk); #1;
    set_req(inst, port, 1'b1, a);
    wait_ack(inst, port, name);
    @(posedge clk); #1;
    set_req(inst, port, 1'b0, a);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flash_mem[32'h000100] = 8'h11; flash_mem[32'h000101] = 8'h22;
    flash_mem[32'h000102] = 8'h33; flash_mem[32'h000103] = 8'h44;
    flash_mem[32'h000200] = 8'hDE; flash_mem[32'h000201] = 8'hAD;
    flash_mem[32'h000202] = 8'hBE; flash_mem[32'h000203] = 8'hEF;
    flash_mem[32'h012344] = 8'hA1; flash_mem[32'h012345] = 8'hB2;
    flash_mem[32'h012346] = 8'hC3; flash_mem[32'h012347] = 8'hD4;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_cs_n",   32'(g_inst[0].cs_n),     32'd1);
    chk("reset_sck",    32'(g_inst[0].sck),      32'd0);
    chk("reset_mosi",   32'(g_inst[0].mosi),     32'd0);
    chk("reset_m0_ack", 32'(g_inst[0].m0_ack),   32'd0);
    chk("reset_m1_ack", 32'(g_inst[0].m1_ack),   32'd0);
    chk("reset_m0_rd",  g_inst[0].m0_rdata,      32'd0);
    chk("reset_m1_rd",  g_inst[0].m1_rdata,      32'd0);
    chk("reset_busy",   32'(g_inst[0].busy),     32'd0);
    chk("reset_cs_n_d3", 32'(g_inst[1].cs_n),    32'd1);

    // Tie right after reset: grant order 0,1,0,1 with back-to-back 2-cycle gaps.
    chk_gap = 1'b1;
    expect_tx(0, 0, 32'h44332211, 32'h03000100, 128);
    expect_tx(0, 1, 32'hD4C3B2A1, 32'h03012344, 128);
    expect_tx(0, 0, 32'hEFBEADDE, 32'h03000200, 128);
    expect_tx(0, 1, 32'h44332211, 32'h03000100, 128);
    @(posedge clk); #1;
    fork
      begin
        set_req(0, 0, 1'b1, 24'h000100);
        wait_ack(0, 0, "fair_p0_a");
        @(posedge clk); #1 set_req(0, 0, 1'b1, 24'h000200);
        wait_ack(0, 0, "fair_p0_b");
        @(posedge clk); #1 set_req(0, 0, 1'b0, 24'h000200);
      end
      begin
        set_req(0, 1, 1'b1, 24'h012347);
        wait_ack(0, 1, "fair_p1_a");
        @(posedge clk); #1 set_req(0, 1, 1'b1, 24'h000103);
        wait_ack(0, 1, "fair_p1_b");
        @(posedge clk); #1 set_req(0, 1, 1'b0, 24'h000103);
      end
    join
    repeat (4) @(negedge clk);
    chk_gap = 1'b0;

    expect_tx(0, 0, 32'h44332211, 32'h03000100, 128);
    read_one(0, 0, 24'h000100, "single_read");

    expect_tx(0, 1, 32'hD4C3B2A1, 32'h03012344, 128);
    read_one(0, 1, 24'h012347, "unaligned");

    expect_tx(1, 0, 32'hEFBEADDE, 32'h03000200, 384);
    read_one(1, 0, 24'h000200, "divider3");

    // Reset during bit 40 of an m0 frame: no ack, outputs back to reset values.
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 24'h000100);
    wait_grant0("rst_mid");
    repeat (80) @(posedge clk);
    #1 rst = 1'b1;
    set_req(0, 0, 1'b0, 24'h000100);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs_n",   32'(g_inst[0].cs_n),   32'd1);
    chk("rst_mid_sck",    32'(g_inst[0].sck),    32'd0);
    chk("rst_mid_m0_ack", 32'(g_inst[0].m0_ack), 32'd0);
    chk("rst_mid_m0_rd",  g_inst[0].m0_rdata,    32'd0);
    chk("rst_mid_m1_rd",  g_inst[0].m1_rdata,    32'd0);
    chk("rst_mid_busy",   32'(g_inst[0].busy),   32'd0);
    repeat (150) @(negedge clk);

    expect_tx(0, 1, 32'h44332211, 32'h03000100, 128);
    read_one(0, 1, 24'h000100, "after_rst_m1");

    // Tie with last grant = 1: port 0 first.
    expect_tx(0, 0, 32'hEFBEADDE, 32'h03000200, 128);
    expect_tx(0, 1, 32'hD4C3B2A1, 32'h03012344, 128);
    @(posedge clk); #1;
    fork
      begin
        set_req(0, 0, 1'b1, 24'h000200);
        wait_ack(0, 0, "tie2_p0");
        @(posedge clk); #1 set_req(0, 0, 1'b0, 24'h000200);
      end
      begin
        set_req(0, 1, 1'b1, 24'h012344);
        wait_ack(0, 1, "tie2_p1");
        @(posedge clk); #1 set_req(0, 1, 1'b0, 24'h012344);
      end
    join
    repeat (4) @(negedge clk);

    // Requester drops req mid-frame: the frame still completes and acks once.
    expect_tx(0, 0, 32'hEFBEADDE, 32'h03000200, 128);
    @(posedge clk); #1;
    set_req(0, 0, 1'b1, 24'h000200);
    wait_grant0("early_drop");
    repeat (30) @(posedge clk);
    #1 set_req(0, 0, 1'b0, 24'h000200);
    wait_ack(0, 0, "early_drop");
    repeat (4) @(negedge clk);
    chk("early_drop_busy", 32'(g_inst[0].busy), 32'd0);
    chk("early_drop_cs_n", 32'(g_inst[0].cs_n), 32'd1);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
